// File: rtl/q_update_engine.sv
// Q-learning update engine: scans max Q[s'][*], computes Q[s][a] += alpha*(r + gamma*maxQ - Q[s][a]), writes it back.
// Latency: N_ACTIONS+3 cycles from accepted request to out_valid (1 cycle for an out-of-range request).
// Backpressure: one request in flight; result held in DONE until out_ready, in_ready low until then.
//
// Ports: clk/rst_n; in_valid/in_ready with in_state/in_action/in_reward/in_next (request);
//        out_valid/out_ready with out_q/out_sat/out_err (result);
//        wr_en/wr_state/wr_action/wr_data (host table write, IDLE only), rd_data (registered table read).
module q_update_engine #(
    parameter int N_STATES  = 36,
    parameter int N_ACTIONS = 4,
    parameter int W         = 32,
    parameter int FRAC      = 24,
    parameter int R_W       = 4,
    parameter logic [W-1:0] GAMMA = 32'h00E66666,
    parameter logic [W-1:0] ALPHA = 32'h00333333
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5:0]     in_state,
    input  logic [2:0]     in_action,
    input  logic [R_W-1:0] in_reward,
    input  logic [5:0]     in_next,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_q,
    output logic           out_sat,
    output logic           out_err,
    input  logic           wr_en,
    input  logic [5:0]     wr_state,
    input  logic [2:0]     wr_action,
    input  logic [W-1:0]   wr_data,
    output logic [W-1:0]   rd_data
);

    localparam int N_ENT = N_STATES * N_ACTIONS;
    localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SCAN, CALC, WRITE, DONE} state_t;

    state_t state, state_nxt;

    logic [W-1:0]   q_tbl [N_ENT];
    logic [5:0]     s_r, n_r;
    logic [2:0]     a_r, cnt;
    logic [R_W-1:0] r_r;
    logic [W-1:0]   max_q, delta_r;
    logic           sat_acc;

    function automatic logic [IDX_W-1:0] ent(input logic [5:0] s, input logic [2:0] a);
        return IDX_W'(int'(s) * N_ACTIONS + int'(a));
    endfunction

    function automatic logic s_in(input logic [5:0] s);
        return int'(s) < N_STATES;
    endfunction

    function automatic logic a_in(input logic [2:0] a);
        return int'(a) < N_ACTIONS;
    endfunction

    function automatic logic signed [2*W-1:0] sx(input logic [W-1:0] v);
        return {{W{v[W-1]}}, v};
    endfunction

    // Returns {saturated, clamped value}.
    function automatic logic [W:0] sat_w(input logic signed [2*W-1:0] x);
        if (x > SAT_MAX)      return {1'b1, 1'b0, {(W-1){1'b1}}};
        else if (x < SAT_MIN) return {1'b1, 1'b1, {(W-1){1'b0}}};
        else                  return {1'b0, x[W-1:0]};
    endfunction

    logic accept, req_ok, sa_ok, wr_ok;

    assign in_ready  = rst_n && (state == IDLE) && !wr_en;
    assign accept    = in_valid && in_ready;
    assign sa_ok     = s_in(in_state) && a_in(in_action);
    assign req_ok    = sa_ok && s_in(in_next);
    assign wr_ok     = s_in(wr_state) && a_in(wr_action);
    assign out_valid = (state == DONE);

    // Arithmetic: target and delta are evaluated in CALC from the finished max,
    // upd in WRITE from the registered delta, so each cycle holds one multiply.
    logic [W-1:0]          scan_val, q_sa, t_val, d_val, u_val;
    logic                  t_sat, d_sat, u_sat;
    logic signed [2*W-1:0] r_ext, g_prod, t_wide, d_wide, a_prod, u_wide;

    assign scan_val = q_tbl[ent(n_r, cnt)];
    assign q_sa     = q_tbl[ent(s_r, a_r)];

    always_comb begin
        r_ext  = {{(2*W-R_W){1'b0}}, r_r};
        g_prod = sx(GAMMA) * sx(max_q);
        t_wide = (r_ext <<< FRAC) + (g_prod >>> FRAC);
        {t_sat, t_val} = sat_w(t_wide);
        d_wide = sx(t_val) - sx(q_sa);
        {d_sat, d_val} = sat_w(d_wide);
        a_prod = sx(ALPHA) * sx(delta_r);
        u_wide = sx(q_sa) + (a_prod >>> FRAC);
        {u_sat, u_val} = sat_w(u_wide);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_ok ? SCAN : DONE;
            SCAN:    if (cnt == 3'(N_ACTIONS - 1)) state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r     <= '0;
            a_r     <= '0;
            n_r     <= '0;
            r_r     <= '0;
            cnt     <= '0;
            max_q   <= '0;
            delta_r <= '0;
            sat_acc <= 1'b0;
            out_q   <= '0;
            out_sat <= 1'b0;
            out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    r_r     <= in_reward;
                    cnt     <= '0;
                    sat_acc <= 1'b0;
                    // Indices are only latched when valid so table reads stay in range.
                    if (req_ok) begin
                        s_r <= in_state;
                        a_r <= in_action;
                        n_r <= in_next;
                    end else begin
                        out_q   <= sa_ok ? q_tbl[ent(in_state, in_action)] : '0;
                        out_sat <= 1'b0;
                        out_err <= 1'b1;
                    end
                end
                SCAN: begin
                    cnt <= cnt + 3'd1;
                    // First entry seeds the max so all-negative rows are handled.
                    if (cnt == '0 || $signed(scan_val) > $signed(max_q))
                        max_q <= scan_val;
                end
                CALC: begin
                    delta_r <= d_val;
                    sat_acc <= t_sat | d_sat;
                end
                WRITE: begin
                    out_q   <= u_val;
                    out_sat <= sat_acc | u_sat;
                    out_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Table and read port. The table is only written in WRITE (engine) or IDLE (host),
    // so SCAN/CALC always see pre-update values, including when s'==s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) q_tbl[i] <= '0;
            rd_data <= '0;
        end else begin
            if (state == WRITE)
                q_tbl[ent(s_r, a_r)] <= u_val;
            else if (state == IDLE && wr_en && wr_ok)
                q_tbl[ent(wr_state, wr_action)] <= wr_data;
            rd_data <= wr_ok ? q_tbl[ent(wr_state, wr_action)] : '0;
        end
    end

endmodule

// File: tb/tb_q_update_engine.sv
module tb_q_update_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_state = '0;
    logic [2:0]  in_action = '0;
    logic [3:0]  in_reward = '0;
    logic [5:0]  in_next = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_q;
    logic        out_sat;
    logic        out_err;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_state = '0;
    logic [2:0]  wr_action = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;

    q_update_engine dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_action(in_action), .in_reward(in_reward), .in_next(in_next),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_sat(out_sat), .out_err(out_err),
        .wr_en(wr_en), .wr_state(wr_state), .wr_action(wr_action), .wr_data(wr_data),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic        sat;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    bit   active = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done = 0;
    int   n_issued = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, after stimulus settles.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            active = 1'b0;
        end else if (out_valid) begin
            if (!active) begin
                active = 1'b1;
                chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    cur = sbq.pop_front();
                    chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                end else begin
                    cur = '{q: 32'd0, sat: 1'b0, err: 1'b0, lat: 0, acc: 0};
                end
            end
            chk("out_q", out_q, cur.q);
            chk("out_sat", 32'(out_sat), 32'(cur.sat));
            chk("out_err", 32'(out_err), 32'(cur.err));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (out_ready) begin
                active = 1'b0;
                n_done++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic host_wr(input logic [5:0] s, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_state = s; wr_action = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_rd(input logic [5:0] s, input logic [2:0] a, input logic [31:0] e, input string name);
        @(negedge clk);
        wr_state = s; wr_action = a;
        @(negedge clk);
        #1 chk(name, rd_data, e);
    endtask

    task automatic wait_done();
        int k = 0;
        while (n_done < n_issued && k < 60) begin
            @(negedge clk);
            #3;
            k++;
        end
        chk("done_timeout", 32'(n_done >= n_issued), 32'd1);
    endtask

    task automatic req(input logic [5:0] s, input logic [2:0] a, input logic [3:0] r, input logic [5:0] n,
                       input logic [31:0] eq, input logic esat, input logic eerr, input int elat,
                       input int hold, input bit scan_wr);
        exp_t e;
        int k;
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid = 1'b1; in_state = s; in_action = a; in_reward = r; in_next = n;
        #1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("accept", 32'(in_ready), 32'd1);
        e.q = eq; e.sat = esat; e.err = eerr; e.lat = elat; e.acc = cyc;
        sbq.push_back(e);
        n_issued++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (scan_wr) begin
            wr_en = 1'b1; wr_state = 6'd8; wr_action = 3'd3; wr_data = 32'h12345678;
            @(negedge clk);
            wr_en = 1'b0;
        end
        if (hold > 0) begin
            k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                #1;
                k++;
            end
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        wait_done();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_q", out_q, 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic update from an all-zero table
        req(6'd5, 3'd2, 4'd1, 6'd6, 32'h00333333, 1'b0, 1'b0, 7, 0, 1'b0);
        check_rd(6'd5, 3'd2, 32'h00333333, "rd_5_2_basic");

        // Discounted max from next state
        do_reset();
        host_wr(6'd6, 3'd1, 32'h02000000);
        check_rd(6'd6, 3'd1, 32'h02000000, "rd_6_1_host");
        req(6'd5, 3'd2, 4'd0, 6'd6, 32'h005C28F5, 1'b0, 1'b0, 7, 0, 1'b0);

        // Saturation of target and delta
        host_wr(6'd6, 3'd0, 32'h7FFFFFFF);
        host_wr(6'd5, 3'd2, 32'h80000000);
        req(6'd5, 3'd2, 4'd15, 6'd6, 32'h9999997F, 1'b1, 1'b0, 7, 0, 1'b0);
        check_rd(6'd5, 3'd2, 32'h9999997F, "rd_5_2_sat");

        // Out-of-range requests
        req(6'd5, 3'd2, 4'd0, 6'd36, 32'h9999997F, 1'b0, 1'b1, 1, 0, 1'b0);
        check_rd(6'd5, 3'd2, 32'h9999997F, "rd_5_2_after_err");
        req(6'd5, 3'd4, 4'd3, 6'd6, 32'h00000000, 1'b0, 1'b1, 1, 0, 1'b0);
        req(6'd40, 3'd1, 4'd0, 6'd6, 32'h00000000, 1'b0, 1'b1, 1, 0, 1'b0);

        // All-negative next-state row: max must be -0.5, not 0
        host_wr(6'd2, 3'd0, 32'hFF000000);
        host_wr(6'd2, 3'd1, 32'hFE000000);
        host_wr(6'd2, 3'd2, 32'hFF800000);
        host_wr(6'd2, 3'd3, 32'h80000000);
        req(6'd3, 3'd0, 4'd1, 6'd2, 32'h001C28F5, 1'b0, 1'b0, 7, 0, 1'b0);

        // Backpressure in DONE, with s'==s
        req(6'd1, 3'd0, 4'd2, 6'd1, 32'h00666666, 1'b0, 1'b0, 7, 5, 1'b0);

        // Host write during SCAN is ignored
        req(6'd7, 3'd0, 4'd1, 6'd7, 32'h00333333, 1'b0, 1'b0, 7, 0, 1'b1);
        check_rd(6'd8, 3'd3, 32'h00000000, "rd_scan_wr_ignored");

        // Host write wins over a simultaneous request
        @(negedge clk);
        in_valid = 1'b1; in_state = 6'd2; in_action = 3'd0; in_reward = 4'd1; in_next = 6'd3;
        wr_en = 1'b1; wr_state = 6'd9; wr_action = 3'd1; wr_data = 32'h00AB0000;
        #1 chk("ready_vs_wr", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; wr_en = 1'b0;
        repeat (10) @(negedge clk);
        #3 chk("no_accept", 32'(n_done), 32'(n_issued));
        check_rd(6'd9, 3'd1, 32'h00AB0000, "rd_wr_priority");

        // Reset during SCAN
        wr_state = 6'd6; wr_action = 3'd0;
        @(negedge clk);
        in_valid = 1'b1; in_state = 6'd5; in_action = 3'd2; in_reward = 4'd1; in_next = 6'd6;
        #1 chk("accept_rst_req", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_q", out_q, 32'd0);
        chk("mid_rst_out_sat", 32'(out_sat), 32'd0);
        chk("mid_rst_out_err", 32'(out_err), 32'd0);
        chk("mid_rst_rd_data", rd_data, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_rd(6'd5, 3'd2, 32'h00000000, "rd_5_2_after_rst");
        check_rd(6'd6, 3'd0, 32'h00000000, "rd_6_0_after_rst");
        check_rd(6'd9, 3'd1, 32'h00000000, "rd_9_1_after_rst");
        #1 chk("post_mid_rst_in_ready", 32'(in_ready), 32'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
